lfsr_period_ctrl: RTL and testbench

//  Sequencer that owns one Galois LFSR and proves its period in hardware: loads a seed, steps
//  the LFSR once per clock, and counts steps until the state returns to the seed. Reports the

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_period_ctrl_if.sv | 25 ++
 rtl/lfsr_core.sv | 41 ++++
 rtl/lfsr_period_ctrl.sv | 136 +++++++++++++
 tb/tb_lfsr_period_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and the Galois step function for the LFSR period measurement block.
package lfsr_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operands are zero-extended to MAX_WIDTH; the result never sets bits above the LFSR width.
  function automatic logic [MAX_WIDTH-1:0] lfsr_next(input logic [MAX_WIDTH-1:0] s,
                                                      input logic [MAX_WIDTH-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_period_ctrl_if.sv
// Control/result bundle between the lab register logic (master) and the period sequencer (slave).
interface lfsr_period_ctrl_if #(parameter int WIDTH = 8);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] seed;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   period;
  logic             maximal;
  logic             lockup_err;
  logic             norep_err;
  logic [WIDTH-1:0] lfsr_q;

  modport master (
    output start, abort, seed,
    input  busy, done, period, maximal, lockup_err, norep_err, lfsr_q
  );

  modport slave (
    input  start, abort, seed,
    output busy, done, period, maximal, lockup_err, norep_err, lfsr_q
  );

endinterface

// File: rtl/lfsr_core.sv
// Galois LFSR state register with synchronous load and step enable; load wins over enable.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH-1:0]     q_reg;
  logic [MAX_WIDTH-1:0] next_wide;

  assign next_wide = lfsr_next(MAX_WIDTH'(q_reg), MAX_WIDTH'(TAPS));
  assign next      = next_wide[WIDTH-1:0];
  assign q         = q_reg;

  generate
    if (WIDTH < MAX_WIDTH) begin : g_unused_hi
      logic unused_next_hi;
      assign unused_next_hi = ^next_wide[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= seed;
    end else if (en) begin
      q_reg <= next;
    end
  end

endmodule

// File: rtl/lfsr_period_ctrl.sv
// Sequencer that loads a seed, steps the LFSR each cycle and counts steps until the seed recurs.
module lfsr_period_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic                clk,
  input  logic                reset,
  lfsr_period_ctrl_if.slave   bus
);

  localparam logic [WIDTH:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] CNT_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_MAX  = CNT_FULL - CNT_ONE;

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_period_ctrl: WIDTH must be within 2..16");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_period_ctrl: TAPS MSB must be set");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic [WIDTH:0]   cnt_reg, cnt_next, cnt_inc;
  logic [WIDTH:0]   period_reg, period_next;
  logic             maximal_reg, maximal_next;
  logic             lockup_reg, lockup_next;
  logic             norep_reg, norep_next;
  logic             core_load, core_en;
  logic [WIDTH-1:0] lfsr_q, lfsr_nx;

  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .en    (core_en),
    .seed  (seed_reg),
    .q     (lfsr_q),
    .next  (lfsr_nx)
  );

  assign cnt_inc = cnt_reg + CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      seed_reg    <= '0;
      cnt_reg     <= '0;
      period_reg  <= '0;
      maximal_reg <= 1'b0;
      lockup_reg  <= 1'b0;
      norep_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      seed_reg    <= seed_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      maximal_reg <= maximal_next;
      lockup_reg  <= lockup_next;
      norep_reg   <= norep_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    seed_next    = seed_reg;
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    maximal_next = maximal_reg;
    lockup_next  = lockup_reg;
    norep_next   = norep_reg;
    core_load    = 1'b0;
    core_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          seed_next  = bus.seed;
          state_next = LOAD;
        end
      end
      LOAD: begin
        // Results clear even on abort so a cancelled run never exposes stale values.
        core_load    = 1'b1;
        cnt_next     = '0;
        period_next  = '0;
        maximal_next = 1'b0;
        lockup_next  = 1'b0;
        norep_next   = 1'b0;
        if (bus.abort) begin
          state_next = IDLE;
        end else if (seed_reg == '0) begin
          lockup_next = 1'b1;
          state_next  = DONE;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          core_en  = 1'b1;
          cnt_next = cnt_inc;
          if (lfsr_nx == seed_reg) begin
            period_next  = cnt_inc;
            maximal_next = (cnt_inc == CNT_MAX);
            state_next   = DONE;
          end else if (cnt_inc == CNT_FULL) begin
            norep_next  = 1'b1;
            period_next = '0;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_reg == LOAD) || (state_reg == RUN);
  assign bus.done       = (state_reg == DONE);
  assign bus.period     = period_reg;
  assign bus.maximal    = maximal_reg;
  assign bus.lockup_err = lockup_reg;
  assign bus.norep_err  = norep_reg;
  assign bus.lfsr_q     = lfsr_q;

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Directed bench for lfsr_period_ctrl: an 8-bit maximal instance and a 4-bit non-primitive one.
module tb_lfsr_period_ctrl;

  typedef struct {
    int          period;
    bit          maximal;
    bit          lockup;
    bit          norep;
    logic [15:0] lfsr;
    int          latency;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   last_period;
  bit   last_maximal;
  exp_t exp_q[$];

  lfsr_period_ctrl_if #(.WIDTH(8)) bus8 ();
  lfsr_period_ctrl_if #(.WIDTH(4)) bus4 ();

  lfsr_period_ctrl #(.WIDTH(8), .TAPS(8'hB8)) u_dut8 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus8)
  );

  lfsr_period_ctrl #(.WIDTH(4), .TAPS(4'hA)) u_dut4 (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: walk the Galois recurrence until the seed recurs.
  function automatic exp_t model(input bit w4, input logic [15:0] seed);
    exp_t        e;
    int          w    = w4 ? 4 : 8;
    int          full = 1 << w;
    logic [15:0] taps = w4 ? 16'h000A : 16'h00B8;
    logic [15:0] s;
    e = '{period: 0, maximal: 0, lockup: 0, norep: 0, lfsr: seed, latency: 2};
    if (seed == 16'h0) begin
      e.lockup = 1'b1;
      return e;
    end
    s = seed;
    e.norep = 1'b1;
    for (int n = 1; n <= full; n++) begin
      s = {1'b0, s[15:1]} ^ (s[0] ? taps : 16'h0);
      if (s == seed) begin
        e.period = n;
        e.norep  = 1'b0;
        break;
      end
    end
    if (e.norep) begin
      e.lfsr    = s;
      e.latency = full + 2;
    end else begin
      e.latency = e.period + 2;
    end
    e.maximal = (e.period == full - 1);
    return e;
  endfunction

  task automatic start_meas(input bit w4, input logic [15:0] seed);
    @(negedge clk);
    if (w4) begin
      bus4.seed  = seed[3:0];
      bus4.start = 1'b1;
    end else begin
      bus8.seed  = seed[7:0];
      bus8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    bus8.start = 1'b0;
  endtask

  task automatic wait_done(input bit w4, input bit chk_lat, input int budget);
    int          k;
    bit          seen;
    exp_t        e;
    logic [16:0] per;
    logic [15:0] lq;
    logic        mx, lk, nr;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      seen = w4 ? bus4.done : bus8.done;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e   = exp_q.pop_front();
    per = w4 ? 17'(bus4.period) : 17'(bus8.period);
    lq  = w4 ? 16'(bus4.lfsr_q) : 16'(bus8.lfsr_q);
    mx  = w4 ? bus4.maximal : bus8.maximal;
    lk  = w4 ? bus4.lockup_err : bus8.lockup_err;
    nr  = w4 ? bus4.norep_err : bus8.norep_err;
    $display("txn w%0d seed=%0h period=%0d maximal=%0b lockup=%0b norep=%0b latency=%0d",
             w4 ? 4 : 8, e.lfsr, per, mx, lk, nr, k + 1);
    check("period", 32'(per), 32'(e.period));
    check("maximal", {31'd0, mx}, {31'd0, e.maximal});
    check("lockup_err", {31'd0, lk}, {31'd0, e.lockup});
    check("norep_err", {31'd0, nr}, {31'd0, e.norep});
    check("lfsr_at_done", 32'(lq), 32'(e.lfsr));
    if (chk_lat) check("latency", 32'(k + 1), 32'(e.latency));
    last_period  = int'(per);
    last_maximal = mx;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", {31'd0, (w4 ? bus4.done : bus8.done)}, 32'd0);
    check("busy_after_done", {31'd0, (w4 ? bus4.busy : bus8.busy)}, 32'd0);
  endtask

  initial begin
    bit seen_busy;
    checks      = 0;
    errors      = 0;
    last_period = 0;
    reset_n     = 1'b0;
    bus8.start  = 1'b0;
    bus8.abort  = 1'b0;
    bus8.seed   = '0;
    bus4.start  = 1'b0;
    bus4.abort  = 1'b0;
    bus4.seed   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("rst_done", {31'd0, bus8.done}, 32'd0);
    check("rst_period", 32'(bus8.period), 32'd0);
    check("rst_flags", {29'd0, bus8.maximal, bus8.lockup_err, bus8.norep_err}, 32'd0);
    check("rst_lfsr", 32'(bus8.lfsr_q), 32'd0);
    check("rst_w4", {27'd0, bus4.busy, bus4.done, bus4.maximal, bus4.lockup_err, bus4.norep_err}, 32'd0);
    reset_n = 1'b1;

    // Maximal-length period from seed 1
    exp_q.push_back(model(1'b0, 16'h01));
    start_meas(1'b0, 16'h01);
    wait_done(1'b0, 1'b1, 400);
    check("t1_period_255", 32'(last_period), 32'd255);
    check("t1_maximal", {31'd0, last_maximal}, 32'd1);

    // Abort at RUN cycle 40, then a clean rerun with the same seed
    start_meas(1'b0, 16'h5A);
    repeat (40) @(posedge clk);
    @(negedge clk);
    bus8.abort = 1'b1;
    check("abort_busy_before", {31'd0, bus8.busy}, 32'd1);
    @(posedge clk);
    #1;
    bus8.abort = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {31'd0, bus8.busy}, 32'd0);
    check("abort_period", 32'(bus8.period), 32'd0);
    check("abort_maximal", {31'd0, bus8.maximal}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", {31'd0, bus8.done}, 32'd0);
      @(negedge clk);
    end
    exp_q.push_back(model(1'b0, 16'h5A));
    start_meas(1'b0, 16'h5A);
    wait_done(1'b0, 1'b1, 400);
    check("t4_period_255", 32'(last_period), 32'd255);

    // All-zero seed locks up
    exp_q.push_back(model(1'b0, 16'h00));
    start_meas(1'b0, 16'h00);
    wait_done(1'b0, 1'b1, 10);

    // Non-primitive 4-bit polynomial: sweep every nonzero seed
    for (int sd = 1; sd < 16; sd++) begin
      exp_q.push_back(model(1'b1, 16'(sd)));
      start_meas(1'b1, 16'(sd));
      wait_done(1'b1, 1'b1, 40);
      if (sd == 1) check("w4_seed1_period", 32'(last_period), 32'd6);
      check("w4_period_3_or_6", {31'd0, (last_period == 3 || last_period == 6)}, 32'd1);
    end

    // Start while busy with a different seed is ignored
    exp_q.push_back(model(1'b0, 16'h01));
    start_meas(1'b0, 16'h01);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus8.seed  = 8'h03;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    wait_done(1'b0, 1'b0, 400);

    // Start held high through DONE restarts from IDLE
    exp_q.push_back(model(1'b0, 16'h80));
    @(negedge clk);
    bus8.seed  = 8'h80;
    bus8.start = 1'b1;
    @(posedge clk);
    wait_done(1'b0, 1'b1, 400);
    seen_busy = 1'b0;
    for (int i = 0; i < 4 && !seen_busy; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen_busy = bus8.busy;
    end
    check("hold_restart_busy", {31'd0, seen_busy}, 32'd1);
    bus8.start = 1'b0;
    exp_q.push_back(model(1'b0, 16'h80));
    wait_done(1'b0, 1'b0, 400);

    // Asynchronous reset in mid-RUN
    start_meas(1'b0, 16'h01);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, bus8.busy}, 32'd1);
    check("pre_reset_lfsr_nz", {31'd0, (bus8.lfsr_q != 8'h00)}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus8.busy}, 32'd0);
    check("async_rst_lfsr", 32'(bus8.lfsr_q), 32'd0);
    check("async_rst_period", 32'(bus8.period), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", {30'd0, bus8.busy, bus8.done}, 32'd0);
    end
    exp_q.push_back(model(1'b0, 16'h01));
    start_meas(1'b0, 16'h01);
    wait_done(1'b0, 1'b1, 400);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
